ex_result_stage: RTL and testbench

//   EX->MEM pipeline stage directly downstream of the 64-bit ALU. Registers ALU result and

---
 rtl/ex_pkg.sv | 47 ++++
 rtl/ex_cond_eval.sv | 49 ++++
 rtl/ex_result_stage.sv | 150 +++++++++++++++
 tb/tb_ex_result_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ----------------------------------------------------------------------------
// Package: ex_pkg
// Purpose:
//   Shared types for the EX result stage.
//   - br_kind_t : which branch rule an instruction uses.
//   - cond_t    : ARMv8 4-bit condition codes used by B.cond.
//   - flags_t   : the architectural NZVC flag word, packed as {n,z,v,c}.
// Ports: none (type package only).
// ----------------------------------------------------------------------------
package ex_pkg;

  typedef enum logic [1:0] {
    BR_NONE  = 2'b00,
    BR_CBZ   = 2'b01,
    BR_CBNZ  = 2'b10,
    BR_BCOND = 2'b11
  } br_kind_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  localparam flags_t FLAGS_RESET = '0;

endpackage

// File: rtl/ex_cond_eval.sv
// ----------------------------------------------------------------------------
// Module: cond_eval
// Purpose:
//   Purely combinational ARMv8 condition evaluator. Given a 4-bit condition
//   code and an NZVC flag word, reports whether the condition holds.
// Ports:
//   cond_i   in  4  condition code (ex_pkg::cond_t encoding)
//   flags_i  in  4  flag word {N,Z,V,C}
//   taken_o  out 1  condition holds
// ----------------------------------------------------------------------------
module cond_eval (
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);
  import ex_pkg::*;

  flags_t flagWord;
  cond_t  condCode;

  assign flagWord = flags_t'(flags_i);
  assign condCode = cond_t'(cond_i);

  // One arm per condition code so each ARMv8 rule reads directly off the table.
  // AL and NV both mean "always" in this pipeline.
  always_comb begin
    taken_o = 1'b0;
    case (condCode)
      COND_EQ: taken_o = flagWord.z;
      COND_NE: taken_o = ~flagWord.z;
      COND_HS: taken_o = flagWord.c;
      COND_LO: taken_o = ~flagWord.c;
      COND_MI: taken_o = flagWord.n;
      COND_PL: taken_o = ~flagWord.n;
      COND_VS: taken_o = flagWord.v;
      COND_VC: taken_o = ~flagWord.v;
      COND_HI: taken_o = flagWord.c & ~flagWord.z;
      COND_LS: taken_o = ~(flagWord.c & ~flagWord.z);
      COND_GE: taken_o = (flagWord.n == flagWord.v);
      COND_LT: taken_o = (flagWord.n != flagWord.v);
      COND_GT: taken_o = ~flagWord.z & (flagWord.n == flagWord.v);
      COND_LE: taken_o = ~(~flagWord.z & (flagWord.n == flagWord.v));
      COND_AL: taken_o = 1'b1;
      COND_NV: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_result_stage.sv
// ----------------------------------------------------------------------------
// Module: ex_result_stage
// Purpose:
//   EX->MEM pipeline register directly after the 64-bit ALU. Registers the ALU
//   result and destination info, owns the architectural NZVC flag register,
//   and resolves CBZ/CBNZ (on the ALU zero flag) and B.cond (on the flag
//   register as it stood before this instruction).
// Configuration:
//   EX_EARLY_BRANCH_EN  when defined, brTaken_early gives the branch decision
//                       combinationally in the EX cycle; otherwise it is 0.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid                    live instruction in EX
//   aluOut[DATA_W]              ALU result
//   negative/zero/overflow/carryOut  ALU flags
//   setFlags                    instruction writes NZVC
//   brKind[2], cond[4]          branch kind and ARMv8 condition
//   rd[REG_AW], regWrite        destination register and write enable
//   stall, flush                hold stage / kill EX instruction
//   out_valid, out_result, out_rd, out_regWrite   registered to MEM
//   flags_q[4]                  NZVC register {N,Z,V,C}
//   brTaken                     registered branch decision
//   brTaken_early               combinational branch decision (optional)
// ----------------------------------------------------------------------------
module ex_result_stage #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] aluOut,
  input  logic              negative,
  input  logic              zero,
  input  logic              overflow,
  input  logic              carryOut,
  input  logic              setFlags,
  input  logic [1:0]        brKind,
  input  logic [3:0]        cond,
  input  logic [REG_AW-1:0] rd,
  input  logic              regWrite,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_regWrite,
  output logic [3:0]        flags_q,
  output logic              brTaken,
  output logic              brTaken_early
);
  import ex_pkg::*;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              regWrite_q, regWrite_d;
  logic              brTaken_q, brTaken_d;
  flags_t            nzcv_q, nzcv_d;

  logic              condTaken;
  logic              decision;

  // B.cond always looks at the registered flags, so an instruction that both
  // sets flags and branches sees the older instruction's flags.
  cond_eval u_cond_eval (
    .cond_i  (cond),
    .flags_i (nzcv_q),
    .taken_o (condTaken)
  );

  // Branch decision for the instruction currently in EX.
  always_comb begin
    decision = 1'b0;
    case (br_kind_t'(brKind))
      BR_NONE:  decision = 1'b0;
      BR_CBZ:   decision = zero;
      BR_CBNZ:  decision = ~zero;
      BR_BCOND: decision = condTaken;
      default:  decision = 1'b0;
    endcase
  end

  // Next-state: flush beats stall; a stall freezes everything including the
  // flags; otherwise either accept the instruction or insert a bubble.
  // The result/rd fields are left alone on bubbles since MEM ignores them.
  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    rd_d       = rd_q;
    regWrite_d = regWrite_q;
    brTaken_d  = brTaken_q;
    nzcv_d     = nzcv_q;
    if (flush) begin
      valid_d    = 1'b0;
      regWrite_d = 1'b0;
      brTaken_d  = 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        valid_d    = 1'b1;
        result_d   = aluOut;
        rd_d       = rd;
        regWrite_d = regWrite;
        brTaken_d  = decision;
        if (setFlags) begin
          nzcv_d = '{n: negative, z: zero, v: overflow, c: carryOut};
        end
      end else begin
        valid_d    = 1'b0;
        regWrite_d = 1'b0;
        brTaken_d  = 1'b0;
      end
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      rd_q       <= '0;
      regWrite_q <= 1'b0;
      brTaken_q  <= 1'b0;
      nzcv_q     <= FLAGS_RESET;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
      regWrite_q <= regWrite_d;
      brTaken_q  <= brTaken_d;
      nzcv_q     <= nzcv_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_result   = result_q;
  assign out_rd       = rd_q;
  assign out_regWrite = regWrite_q;
  assign flags_q      = nzcv_q;
  assign brTaken      = brTaken_q;

  // The early decision ignores stall on purpose: fetch can redirect while MEM
  // is still holding the stage.
`ifdef EX_EARLY_BRANCH_EN
  assign brTaken_early = decision & in_valid & ~flush;
`else
  assign brTaken_early = 1'b0;
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// ----------------------------------------------------------------------------
// Testbench: tb_ex_result_stage
// Purpose:
//   Directed stimulus for ex_result_stage with a bench-side behavioural model
//   compared every cycle, plus hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_ex_result_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [63:0] aluOut;
  logic        negative, zero, overflow, carryOut;
  logic        setFlags;
  logic [1:0]  brKind;
  logic [3:0]  cond;
  logic [4:0]  rd;
  logic        regWrite;
  logic        stall, flush;
  logic        out_valid;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_regWrite;
  logic [3:0]  flags_q;
  logic        brTaken;
  logic        brTaken_early;

  int compared   = 0;
  int mismatched = 0;

  ex_result_stage #(.DATA_W(64), .REG_AW(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .aluOut        (aluOut),
    .negative      (negative),
    .zero          (zero),
    .overflow      (overflow),
    .carryOut      (carryOut),
    .setFlags      (setFlags),
    .brKind        (brKind),
    .cond          (cond),
    .rd            (rd),
    .regWrite      (regWrite),
    .stall         (stall),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_result    (out_result),
    .out_rd        (out_rd),
    .out_regWrite  (out_regWrite),
    .flags_q       (flags_q),
    .brTaken       (brTaken),
    .brTaken_early (brTaken_early)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ARMv8 conditions as pairs: the upper three bits pick a base test, the
  // low bit inverts it (except for the always-pair 111x).
  function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy, base;
    logic [2:0] grp;
    {n, z, v, cy} = f;
    grp = c[3:1];
    case (grp)
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = (n == v) && !z;
      default: base = 1'b1;
    endcase
    return (grp != 3'd7 && c[0]) ? !base : base;
  endfunction

  function automatic logic modelDecision(input logic [1:0] bk, input logic [3:0] c,
                                         input logic z, input logic [3:0] f);
    case (bk)
      2'd1:    return z;
      2'd2:    return !z;
      2'd3:    return condHolds(c, f);
      default: return 1'b0;
    endcase
  endfunction

  // Behavioural model: architectural state of the stage as MEM should see it.
  logic        modelStarted = 1'b0;
  logic        mValid, mRegWrite, mBr;
  logic [63:0] mResult;
  logic [4:0]  mRd;
  logic [3:0]  mFlags;

  always @(posedge clk) begin
    modelStarted = 1'b1;
    if (reset) begin
      mValid = 0; mRegWrite = 0; mBr = 0; mResult = 0; mRd = 0; mFlags = 4'b0000;
    end else if (flush) begin
      mValid = 0; mRegWrite = 0; mBr = 0;
    end else if (!stall) begin
      if (in_valid) begin
        mBr       = modelDecision(brKind, cond, zero, mFlags);
        mValid    = 1;
        mResult   = aluOut;
        mRd       = rd;
        mRegWrite = regWrite;
        if (setFlags) mFlags = {negative, zero, overflow, carryOut};
      end else begin
        mValid = 0; mRegWrite = 0; mBr = 0;
      end
    end
  end

  // Compare process: mid-cycle, every cycle once the model is live.
  always @(negedge clk) begin
    if (modelStarted) begin
      checkOutput("model_out_valid", 64'(out_valid), 64'(mValid));
      checkOutput("model_out_regWrite", 64'(out_regWrite), 64'(mRegWrite));
      checkOutput("model_flags_q", 64'(flags_q), 64'(mFlags));
      checkOutput("model_brTaken", 64'(brTaken), 64'(mBr));
      if (mValid) begin
        checkOutput("model_out_result", out_result, mResult);
        checkOutput("model_out_rd", 64'(out_rd), 64'(mRd));
      end
`ifdef EX_EARLY_BRANCH_EN
      checkOutput("model_brTaken_early", 64'(brTaken_early),
                  64'(modelDecision(brKind, cond, zero, mFlags) && in_valid && !flush && !reset));
`else
      checkOutput("model_brTaken_early", 64'(brTaken_early), 64'(0));
`endif
    end
  end

  // Drive one set of EX inputs without advancing time.
  task automatic driveInputs(input logic iv, input logic [63:0] alu, input logic [3:0] nzvc,
                             input logic sf, input logic [1:0] bk, input logic [3:0] cd,
                             input logic [4:0] rdv, input logic rw, input logic st,
                             input logic fl);
    in_valid = iv; aluOut = alu;
    {negative, zero, overflow, carryOut} = nzvc;
    setFlags = sf; brKind = bk; cond = cd; rd = rdv; regWrite = rw;
    stall = st; flush = fl;
  endtask

  // Drive inputs and step through one rising edge; outputs are then settled.
  task automatic applyStimulus(input logic iv, input logic [63:0] alu, input logic [3:0] nzvc,
                               input logic sf, input logic [1:0] bk, input logic [3:0] cd,
                               input logic [4:0] rdv, input logic rw, input logic st,
                               input logic fl);
    driveInputs(iv, alu, nzvc, sf, bk, cd, rdv, rw, st, fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    driveInputs(1, 64'h55, 4'b1111, 1, 2'd0, 4'h0, 5'd1, 1, 0, 0);

    // Reset held two cycles with a live, flag-setting instruction present.
    applyStimulus(1, 64'h55, 4'b1111, 1, 2'd0, 4'h0, 5'd1, 1, 0, 0);
    applyStimulus(1, 64'h55, 4'b1111, 1, 2'd0, 4'h0, 5'd1, 1, 0, 0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_flags", 64'(flags_q), 64'h0);
    reset = 1'b0;
    applyStimulus(0, 64'h0, 4'b0000, 0, 2'd0, 4'h0, 5'd0, 0, 0, 0);
    checkOutput("post_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("post_rst_out_result", out_result, 64'd0);
    checkOutput("post_rst_out_rd", 64'(out_rd), 64'd0);
    checkOutput("post_rst_regWrite", 64'(out_regWrite), 64'd0);
    checkOutput("post_rst_flags", 64'(flags_q), 64'h0);
    checkOutput("post_rst_brTaken", 64'(brTaken), 64'd0);

    // SUBS giving zero with carry set.
    applyStimulus(1, 64'h0, 4'b0101, 1, 2'd0, 4'h0, 5'd3, 1, 0, 0);
    checkOutput("subs_flags", 64'(flags_q), 64'h5);
    checkOutput("subs_out_result", out_result, 64'h0);
    checkOutput("subs_out_valid", 64'(out_valid), 64'd1);
    checkOutput("subs_out_rd", 64'(out_rd), 64'd3);

    // B.EQ then B.GT on flags 0101.
    applyStimulus(1, 64'h10, 4'b0000, 0, 2'd3, 4'h0, 5'd0, 0, 0, 0);
    checkOutput("beq_taken", 64'(brTaken), 64'd1);
    applyStimulus(1, 64'h10, 4'b0000, 0, 2'd3, 4'hC, 5'd0, 0, 0, 0);
    checkOutput("bgt_not_taken", 64'(brTaken), 64'd0);

    // Set N=1, V=0, then B.GE (not taken) and B.LT (taken).
    applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1, 2'd0, 4'h0, 5'd5, 1, 0, 0);
    checkOutput("neg_flags", 64'(flags_q), 64'h8);
    applyStimulus(1, 64'h20, 4'b0000, 0, 2'd3, 4'hA, 5'd0, 0, 0, 0);
    checkOutput("bge_not_taken", 64'(brTaken), 64'd0);
    applyStimulus(1, 64'h1234, 4'b0000, 0, 2'd3, 4'hB, 5'd7, 1, 0, 0);
    checkOutput("blt_taken", 64'(brTaken), 64'd1);

    // Three stalled cycles with new flag-setting inputs: nothing moves.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 64'hDEAD, 4'b1100, 1, 2'd3, 4'h1, 5'd9, 0, 1, 0);
      checkOutput("stall_out_result", out_result, 64'h1234);
      checkOutput("stall_out_rd", 64'(out_rd), 64'd7);
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_brTaken", 64'(brTaken), 64'd1);
      checkOutput("stall_flags", 64'(flags_q), 64'h8);
    end
    // Flush wins over stall.
    applyStimulus(1, 64'hDEAD, 4'b1100, 1, 2'd3, 4'h1, 5'd9, 1, 1, 1);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_regWrite", 64'(out_regWrite), 64'd0);
    checkOutput("flush_brTaken", 64'(brTaken), 64'd0);
    checkOutput("flush_flags", 64'(flags_q), 64'h8);

    // CBNZ on a non-zero result with the top bit set.
    driveInputs(1, 64'h8000_0000_0000_0000, 4'b0000, 0, 2'd2, 4'h0, 5'd2, 0, 0, 0);
    #1;
`ifdef EX_EARLY_BRANCH_EN
    checkOutput("cbnz_early", 64'(brTaken_early), 64'd1);
`else
    checkOutput("cbnz_early_off", 64'(brTaken_early), 64'd0);
`endif
    @(posedge clk);
    #1;
    checkOutput("cbnz_taken", 64'(brTaken), 64'd1);
    checkOutput("cbnz_flags", 64'(flags_q), 64'h8);
    checkOutput("cbnz_result", out_result, 64'h8000_0000_0000_0000);

    // Flag-setting B.EQ sees the older flags (Z=0), then Z becomes 1.
    applyStimulus(1, 64'h0, 4'b0100, 1, 2'd3, 4'h0, 5'd0, 0, 0, 0);
    checkOutput("no_bypass_taken", 64'(brTaken), 64'd0);
    checkOutput("no_bypass_flags", 64'(flags_q), 64'h4);

    // CBZ taken, then a bubble clears valid and brTaken.
    applyStimulus(1, 64'h0, 4'b0100, 0, 2'd1, 4'h0, 5'd4, 1, 0, 0);
    checkOutput("cbz_taken", 64'(brTaken), 64'd1);
    applyStimulus(0, 64'h0, 4'b0000, 0, 2'd1, 4'h0, 5'd4, 1, 0, 0);
    checkOutput("bubble_valid", 64'(out_valid), 64'd0);
    checkOutput("bubble_brTaken", 64'(brTaken), 64'd0);

    // Sweep all conditions across several flag patterns, with occasional
    // stall and flush cycles; the model compare covers every cycle.
    for (int p = 0; p < 16; p += 3) begin
      applyStimulus(1, 64'(p), 4'(p), 1, 2'd0, 4'h0, 5'(p), 1, 0, 0);
      for (int c = 0; c < 16; c++) begin
        applyStimulus(1, 64'(c * 17 + p), 4'(15 - c), (c % 4) == 3, 2'd3, 4'(c),
                      5'(c), 1, c == 7, c == 11);
      end
    end

    applyStimulus(0, 64'h0, 4'b0000, 0, 2'd0, 4'h0, 5'd0, 0, 0, 0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
